// File: rtl/branch_truth_checker_if.sv
// Resolved-branch event channel from the fetch unit to the truth checker.
// The fetch unit drives the event fields; the checker answers with ev_ready.
interface branch_truth_checker_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [31:0] ev_pc;
  logic        ev_taken;
  logic [31:0] ev_target;

  modport master (output ev_valid, ev_pc, ev_taken, ev_target, input ev_ready);
  modport slave  (input ev_valid, ev_pc, ev_taken, ev_target, output ev_ready);
endinterface

// File: rtl/branch_truth_checker.sv
// Walks the branch ground-truth table in order and checks each resolved branch
// from the fetch unit against it, keeping pass/fail statistics.
//
// state | meaning
// IDLE  | no run active, events refused
// FETCH | pointer presented to storage, waiting out the read latency
// CHECK | entry data valid; accept one event or detect end of table
// DONE  | run finished; every further event is an unexpected failure
module branch_truth_checker #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  branch_truth_checker_if.slave ev,
  output logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  gt_valid,
  input  logic [31:0]           gt_pc,
  input  logic                  gt_taken,
  input  logic [31:0]           gt_target,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  checked_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  err_pulse,
  output logic [1:0]            err_kind,
  output logic [ADDR_WIDTH-1:0] first_err_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] KIND_EXTRA  = 2'b00;
  localparam logic [1:0] KIND_PC     = 2'b01;
  localparam logic [1:0] KIND_DIR    = 2'b10;
  localparam logic [1:0] KIND_TARGET = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [CNT_WIDTH-1:0]  chk_nxt, mis_nxt;
  logic [ADDR_WIDTH-1:0] first_nxt;
  logic                  err_seen, seen_nxt;
  logic [1:0]            kind_nxt, kind_new;
  logic                  pulse_nxt, pass_nxt;
  logic                  accept, fail;
  logic                  cmp_fail;
  logic [1:0]            cmp_kind;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
    return (x == {CNT_WIDTH{1'b1}}) ? x : x + CNT_ONE;
  endfunction

  assign lookup_addr = ptr;
  assign busy        = (state == FETCH) || (state == CHECK);
  assign done        = (state == DONE);
  assign ev.ev_ready = ((state == CHECK) && gt_valid) || (state == DONE);
  assign accept      = ev.ev_valid && ev.ev_ready;

  // Target only matters when both sides agree the branch was taken.
  always_comb begin
    cmp_fail = 1'b0;
    cmp_kind = KIND_EXTRA;
    if (ev.ev_pc != gt_pc) begin
      cmp_fail = 1'b1;
      cmp_kind = KIND_PC;
    end else if (ev.ev_taken != gt_taken) begin
      cmp_fail = 1'b1;
      cmp_kind = KIND_DIR;
    end else if (ev.ev_taken && (ev.ev_target != gt_target)) begin
      cmp_fail = 1'b1;
      cmp_kind = KIND_TARGET;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    chk_nxt   = checked_count;
    mis_nxt   = mismatch_count;
    first_nxt = first_err_idx;
    seen_nxt  = err_seen;
    kind_nxt  = err_kind;
    pulse_nxt = 1'b0;
    fail      = 1'b0;
    kind_new  = KIND_EXTRA;

    // start outranks any event presented in the same cycle; that event is dropped.
    if (start) begin
      state_nxt = FETCH;
      ptr_nxt   = '0;
      chk_nxt   = '0;
      mis_nxt   = '0;
      first_nxt = '0;
      seen_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        FETCH: state_nxt = CHECK;
        CHECK: begin
          if (!gt_valid) begin
            state_nxt = DONE;
          end else if (accept) begin
            chk_nxt  = sat_inc(checked_count);
            fail     = cmp_fail;
            kind_new = cmp_kind;
            if (ptr == PTR_MAX) begin
              state_nxt = DONE;
            end else begin
              ptr_nxt   = ptr + PTR_ONE;
              state_nxt = FETCH;
            end
          end
        end
        DONE: begin
          if (accept) begin
            fail     = 1'b1;
            kind_new = KIND_EXTRA;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // The pointer is never advanced past the last entry, so in DONE it already
    // names either the invalid terminator or the final index.
    if (fail) begin
      pulse_nxt = 1'b1;
      kind_nxt  = kind_new;
      mis_nxt   = sat_inc(mismatch_count);
      if (!err_seen) begin
        first_nxt = ptr;
        seen_nxt  = 1'b1;
      end
    end

    pass_nxt = (state_nxt == DONE) && (mis_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      checked_count  <= '0;
      mismatch_count <= '0;
      first_err_idx  <= '0;
      err_seen       <= 1'b0;
      err_kind       <= KIND_EXTRA;
      err_pulse      <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      checked_count  <= chk_nxt;
      mismatch_count <= mis_nxt;
      first_err_idx  <= first_nxt;
      err_seen       <= seen_nxt;
      err_kind       <= kind_nxt;
      err_pulse      <= pulse_nxt;
      pass           <= pass_nxt;
    end
  end

endmodule
